// File: rtl/dispatch_stage_pkg.sv
// Shared types and sizing for the dispatch stage and its producer table.
// Global RS slot = fu*RS_ENTRIES + entry.
package dispatch_stage_pkg;

    localparam int CORE_NUM_FUS    = 2;
    localparam int CORE_RS_ENTRIES = 8;
    localparam int CORE_NUM_PREGS  = 64;

    localparam int PREG_W    = $clog2(CORE_NUM_PREGS);
    localparam int FU_W      = $clog2(CORE_NUM_FUS);
    localparam int IDX_W     = $clog2(CORE_RS_ENTRIES);
    localparam int SLOT_W    = $clog2(CORE_RS_ENTRIES * CORE_NUM_FUS);
    localparam int NUM_SLOTS = CORE_RS_ENTRIES * CORE_NUM_FUS;

    typedef struct packed {
        logic              instr_valid;
        logic [7:0]        opcode;
        logic [PREG_W-1:0] dst_preg;
        logic [PREG_W-1:0] src1_preg;
        logic [PREG_W-1:0] src2_preg;
        logic [15:0]       imm;
    } disp_packet_t;

    typedef struct packed {
        logic              valid;
        logic [SLOT_W-1:0] slot;
    } producer_entry_t;

    function automatic logic [SLOT_W-1:0] make_slot(input logic [FU_W-1:0]  fu,
                                                    input logic [IDX_W-1:0] idx);
        return SLOT_W'(fu) * SLOT_W'(CORE_RS_ENTRIES) + SLOT_W'(idx);
    endfunction

endpackage

// File: rtl/dispatch_stage_if.sv
// Rename-side and scheduler-side signals of the dispatch stage.
// slave is the dispatch stage's view; master is the surrounding pipeline's view.
interface dispatch_stage_if #(
    parameter int NUM_FUS    = dispatch_stage_pkg::CORE_NUM_FUS,
    parameter int RS_ENTRIES = dispatch_stage_pkg::CORE_RS_ENTRIES,
    parameter int PERF_W     = 16
);
    localparam int FU_W      = $clog2(NUM_FUS);
    localparam int IDX_W     = $clog2(RS_ENTRIES);
    localparam int NUM_SLOTS = NUM_FUS * RS_ENTRIES;

    logic                               flush;
    logic                               in_valid;
    logic                               in_ready;
    dispatch_stage_pkg::disp_packet_t   in_pkt;
    logic [FU_W-1:0]                    in_fu_sel;
    logic [NUM_FUS-1:0]                 disp_valid;
    dispatch_stage_pkg::disp_packet_t   disp_pkt;
    logic [NUM_SLOTS-1:0]               dependency_mask;
    logic [NUM_FUS-1:0]                 rs_full;
    logic [NUM_FUS*IDX_W-1:0]           rs_entry_idx;
    logic [NUM_SLOTS-1:0]               global_ready_mask;
    logic [PERF_W-1:0]                  stall_count;

    modport master (
        output flush, in_valid, in_pkt, in_fu_sel, rs_full, rs_entry_idx, global_ready_mask,
        input  in_ready, disp_valid, disp_pkt, dependency_mask, stall_count
    );

    modport slave (
        input  flush, in_valid, in_pkt, in_fu_sel, rs_full, rs_entry_idx, global_ready_mask,
        output in_ready, disp_valid, disp_pkt, dependency_mask, stall_count
    );

endinterface

// File: rtl/dispatch_stage_producer_table.sv
// Per-preg record of the RS slot producing it: 2 async read ports, 1 write port, mask clear.
// A write beats a same-edge clear of the same entry; flush invalidates everything.
module producer_table
    import dispatch_stage_pkg::*;
#(
    parameter int NUM_PREGS = CORE_NUM_PREGS,
    parameter int NUM_SLOTS = CORE_NUM_FUS * CORE_RS_ENTRIES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic [NUM_SLOTS-1:0] i_clr_mask,
    input  logic                 i_wr_en,
    input  logic [PREG_W-1:0]    i_wr_addr,
    input  logic [SLOT_W-1:0]    i_wr_slot,
    input  logic [PREG_W-1:0]    i_rd0_addr,
    input  logic [PREG_W-1:0]    i_rd1_addr,
    output producer_entry_t      o_rd0,
    output producer_entry_t      o_rd1
);

    producer_entry_t r_tab [NUM_PREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                r_tab[i] <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                r_tab[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                if (r_tab[i].valid && i_clr_mask[r_tab[i].slot]) begin
                    r_tab[i].valid <= 1'b0;
                end
            end
            // Issued after the clears so the new producer survives a same-edge wakeup.
            if (i_wr_en) begin
                r_tab[i_wr_addr] <= '{valid: 1'b1, slot: i_wr_slot};
            end
        end
    end

    assign o_rd0 = r_tab[i_rd0_addr];
    assign o_rd1 = r_tab[i_rd1_addr];

endmodule

// File: rtl/dispatch_stage.sv
// Single-register dispatch stage: looks up source producers and strobes the selected scheduler.
// Full throughput; holds the packet stable while the target scheduler reports full.
module dispatch_stage
    import dispatch_stage_pkg::*;
#(
    parameter int NUM_FUS    = CORE_NUM_FUS,
    parameter int RS_ENTRIES = CORE_RS_ENTRIES,
    parameter int NUM_PREGS  = CORE_NUM_PREGS,
    parameter int PERF_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    dispatch_stage_if.slave  bus
);

    localparam int NUM_SLOTS = NUM_FUS * RS_ENTRIES;

    logic                  r_out_vld;
    disp_packet_t          r_out_pkt;
    logic [FU_W-1:0]       r_out_fu;
    logic [PERF_W-1:0]     r_stall_cnt;

    logic                  w_full_sel;
    logic                  w_accept;
    logic                  w_stall;
    logic                  w_load;
    logic                  w_wr_en;
    logic [IDX_W-1:0]      w_alloc_idx;
    producer_entry_t       w_src1;
    producer_entry_t       w_src2;
    logic [NUM_SLOTS-1:0]  w_dep_mask;
    logic [NUM_FUS-1:0]    w_disp_valid;

    assign w_full_sel  = bus.rs_full[r_out_fu];
    assign w_accept    = r_out_vld && !w_full_sel;
    assign w_stall     = r_out_vld && w_full_sel;
    assign w_load      = bus.in_valid && bus.in_ready;
    assign w_alloc_idx = bus.rs_entry_idx[r_out_fu*IDX_W +: IDX_W];
    assign w_wr_en     = w_accept && (r_out_pkt.dst_preg != '0);

    assign bus.in_ready        = !r_out_vld || w_accept;
    assign bus.disp_pkt        = r_out_pkt;
    assign bus.dependency_mask = w_dep_mask;
    assign bus.disp_valid      = w_disp_valid;
    assign bus.stall_count     = r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_out_pkt <= '0;
            r_out_fu  <= '0;
        end else if (bus.flush) begin
            r_out_vld <= 1'b0;
        end else if (w_load) begin
            r_out_vld <= 1'b1;
            r_out_pkt <= bus.in_pkt;
            r_out_fu  <= bus.in_fu_sel;
        end else if (w_accept) begin
            r_out_vld <= 1'b0;
        end
    end

    // Performance counter survives flush so stalls across a mispredict stay visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    producer_table #(
        .NUM_PREGS (NUM_PREGS),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_producer_table (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (bus.flush),
        .i_clr_mask (bus.global_ready_mask),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (r_out_pkt.dst_preg),
        .i_wr_slot  (make_slot(r_out_fu, w_alloc_idx)),
        .i_rd0_addr (r_out_pkt.src1_preg),
        .i_rd1_addr (r_out_pkt.src2_preg),
        .o_rd0      (w_src1),
        .o_rd1      (w_src2)
    );

    // Ready-mask bypass covers the producer waking up in this very cycle.
    always_comb begin
        w_dep_mask = '0;
        if (w_src1.valid && (r_out_pkt.src1_preg != '0) && !bus.global_ready_mask[w_src1.slot]) begin
            w_dep_mask[w_src1.slot] = 1'b1;
        end
        if (w_src2.valid && (r_out_pkt.src2_preg != '0) && !bus.global_ready_mask[w_src2.slot]) begin
            w_dep_mask[w_src2.slot] = 1'b1;
        end
    end

    always_comb begin
        w_disp_valid = '0;
        if (w_accept) begin
            w_disp_valid[r_out_fu] = 1'b1;
        end
    end

    a_fu_legal: assert property (@(posedge clk) disable iff (rst)
        r_out_vld |-> (int'(r_out_fu) < NUM_FUS));

endmodule

// File: doc/dispatch_stage.md
Name: dispatch_stage

Overview:
- Producer side of the dispatch-to-scheduler interface; sits between rename and the per-FU schedulers.
- Accepts one renamed instruction per cycle and holds it in a single output register.
- Looks up the RS slot that produces each source preg in a producer table and drives disp_valid, disp_pkt and dependency_mask to the FU-selected scheduler.
- Records the allocated slot as the new producer of dst_preg; clears table entries as global_ready_mask reports producers ready.

Parameters:
- NUM_FUS, CORE_PKG::NUM_FUS, number of schedulers/FUs.
- RS_ENTRIES, CORE_PKG::RS_ENTRIES, entries per scheduler.
- NUM_PREGS, CORE_PKG::NUM_PREGS, physical registers.
- PERF_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush
- in_valid  in  1  rename has an instruction
- in_ready  out  1  stage can accept
- in_pkt  in  disp_packet_t  renamed instruction
- in_fu_sel  in  $clog2(NUM_FUS)  target scheduler
- disp_valid  out  NUM_FUS  one-hot dispatch strobe
- disp_pkt  out  disp_packet_t  held packet, broadcast to all schedulers
- dependency_mask  out  RS_ENTRIES*NUM_FUS  producer slots still pending
- rs_full  in  NUM_FUS  per-scheduler full
- rs_entry_idx  in  NUM_FUS*$clog2(RS_ENTRIES)  entry allocated by each scheduler this cycle
- global_ready_mask  in  RS_ENTRIES*NUM_FUS  slots whose result is now ready
- stall_count  out  PERF_W  cycles held by rs_full

Behaviour:
- Slot numbering:
  - Global slot = fu*RS_ENTRIES + entry.
  - Slot index width is SLOT_W = $clog2(RS_ENTRIES*NUM_FUS).
- Reset (async):
  - Output register invalid; disp_valid = 0; disp_pkt = 0; dependency_mask = 0.
  - All producer table entries invalid; stall_count = 0; in_ready = 1.
- Output register: out_vld, out_pkt, out_fu.
- Dispatch handshake:
  - disp_valid[out_fu] = out_vld && !rs_full[out_fu]; all other bits are 0.
  - accept = out_vld && !rs_full[out_fu].
- Input handshake:
  - in_ready = !out_vld || accept; full throughput, no bubble.
  - On in_valid && in_ready, the register loads in_pkt/in_fu_sel on the next edge.
  - Otherwise, on accept, out_vld clears.
  - While the register is held, its contents are stable.
- Producer table: NUM_PREGS entries of {valid, slot[SLOT_W-1:0]}.
- dependency_mask (combinational from table at output stage):
  - Set bit slot(src) for src1_preg and src2_preg when the entry is valid, src != 0, and global_ready_mask[slot] = 0.
  - The global_ready_mask bypass prevents a missed wakeup in the cycle a producer becomes ready.
  - src1 == src2 sets a single bit.
- Table update, each edge, in this order:
  1. Clear every valid entry whose slot bit is set in global_ready_mask.
  2. On accept with dst_preg != 0, write table[dst_preg] = {1, out_fu*RS_ENTRIES + rs_entry_idx[out_fu]}.
  - The write wins over a same-cycle clear of the same preg.
- Back-to-back dependency:
  - Producer A is accepted in cycle N; consumer B sits in the output register in N+1.
  - B's dependency_mask includes A's slot because the table is updated at the N/N+1 edge.
- Self-dependency: an instruction whose src equals its own dst_preg uses the old producer, since the lookup precedes the write.
- flush (synchronous, priority over everything but rst):
  - Next edge: out_vld = 0, all table entries invalid.
  - disp_valid is still combinationally asserted in the flush cycle if accept holds; schedulers are flushed in the same cycle.
- stall_count: increments when out_vld && rs_full[out_fu], saturates at all-ones; not cleared by flush.
- instr_valid in the packet is passed through unchanged.
- out_fu >= NUM_FUS is illegal; assertion only.

Decomposition:
- Already in CORE_PKG: disp_packet_t, NUM_FUS, RS_ENTRIES, NUM_PREGS.
- Add to CORE_PKG: SLOT_W and producer_entry_t {valid, slot}.
- One sub-module, producer_table: array storage with 2 read ports, 1 write port and mask-clear.

Test Plan:
- Setup for all scenarios: NUM_FUS=2, RS_ENTRIES=8.
- No deps: reset; send dst=10, src=20/30, fu=0; scheduler returns idx 0 -> disp_valid=01, dependency_mask=0; table[10]={1,0}.
- Back-to-back dependency:
  - Send A (dst=15, fu=1, idx=3), then B (src1=15, fu=0).
  - B's dependency_mask has only bit 11 set, and B dispatches the cycle after A.
- Bypass: B pending on slot 11; assert global_ready_mask bit 11 in B's dispatch cycle -> dependency_mask=0 that cycle; table[15] invalid next cycle.
- Backpressure:
  - Hold rs_full[0]=1 for 5 cycles with an instruction held -> disp_valid=0, in_ready=0, disp_pkt stable, stall_count=5.
  - Release rs_full[0] -> dispatch; in_ready=1 in the same cycle.
- Write vs clear race:
  - table[7]={1,2}; in one cycle assert global_ready_mask bit 2 and accept a new dst=7 allocated idx 5 on fu 0.
  - Result: table[7]={1,5}.
- Flush/reset mid-operation:
  - Flush while an instruction is held and table[10] is valid -> next cycle out_vld=0, a lookup of src=10 gives mask 0.
  - Assert rst asynchronously mid-cycle -> all outputs immediately at reset values.
